// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer: read, capture, then write back (stores) or register the load result.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned word/half accesses like an illegal tipo.
module mem_access_seq #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  tipo,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic [3:0]  fmt_tipo,
  output logic [63:0] fmt_reg,
  output logic [63:0] fmt_mem,
  input  logic [63:0] fmt_res
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CAPT,
    S_LOAD,
    S_WRITE
  } state_t;

  localparam logic [3:0] WAIT_LAST = (MEM_LAT >= 2) ? 4'(MEM_LAT - 2) : 4'd0;
  localparam bit         SKIP_WAIT = (MEM_LAT <= 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  tipo_q, tipo_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] fmem_q, fmem_d;
  logic [63:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic tipo_legal;
  logic misaligned;

  assign tipo_legal = (tipo <= 4'd8);

`ifdef MEM_ALIGN_CHECK_EN
  // Word codes: SW, LW, LWU. Half codes: SH, LH, LHU.
  assign misaligned = (((tipo == 4'd0) || (tipo == 4'd3) || (tipo == 4'd8)) && (addr[1:0] != 2'b00)) ||
                      (((tipo == 4'd1) || (tipo == 4'd4) || (tipo == 4'd7)) && addr[0]);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tipo_d  = tipo_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fmem_d  = fmem_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (!tipo_legal || misaligned) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            tipo_d  = tipo;
            addr_d  = addr;
            wdata_d = wdata;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        cnt_d   = 4'd0;
        state_d = SKIP_WAIT ? S_CAPT : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LAST) state_d = S_CAPT;
      end
      S_CAPT: begin
        fmem_d  = mem_rdata;
        state_d = (tipo_q >= 4'd3) ? S_LOAD : S_WRITE;
      end
      S_LOAD: begin
        rdata_d = fmt_res;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tipo_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      fmem_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tipo_q  <= tipo_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fmem_q  <= fmem_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Memory strobes decode straight from state; address and write data are gated to 0 when idle.
  assign busy      = (state_q != S_IDLE);
  assign mem_rd    = (state_q == S_READ);
  assign mem_wr    = (state_q == S_WRITE);
  assign mem_addr  = busy ? addr_q : 64'd0;
  assign mem_wdata = mem_wr ? fmt_res : 64'd0;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign fmt_tipo  = tipo_q;
  assign fmt_reg   = wdata_q;
  assign fmt_mem   = fmem_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Randomized bench for mem_access_seq with a latency-accurate memory and a formatter model.
// Define MEM_ALIGN_CHECK_EN here as well when building the design with alignment checking.
module tb_mem_access_seq;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  tipo;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        busy, done, err;
  logic [63:0] rdata;
  logic [63:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [3:0]  fmt_tipo;
  logic [63:0] fmt_reg, fmt_mem, fmt_res;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mem_word;
  logic [63:0] pipe [LAT];
  logic [63:0] exp_rdata;

  logic [3:0]  nxt_tp;
  logic [63:0] nxt_ad, nxt_wd;

  mem_access_seq #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .tipo(tipo), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .fmt_tipo(fmt_tipo), .fmt_reg(fmt_reg), .fmt_mem(fmt_mem), .fmt_res(fmt_res)
  );

  always #5 clk = ~clk;

  // Read data appears LAT cycles after the mem_rd cycle; garbage otherwise.
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= mem_rd ? mem_word : {$urandom, $urandom};
  end
  assign mem_rdata = pipe[LAT-1];

  function automatic logic [63:0] fmt_model(input logic [3:0] tp, input logic [63:0] rg,
                                            input logic [63:0] m);
    case (tp)
      4'd0:    fmt_model = {m[63:32], rg[31:0]};
      4'd1:    fmt_model = {m[63:16], rg[15:0]};
      4'd2:    fmt_model = {m[63:8], rg[7:0]};
      4'd3:    fmt_model = {{32{m[31]}}, m[31:0]};
      4'd4:    fmt_model = {{48{m[15]}}, m[15:0]};
      4'd5:    fmt_model = {{56{m[7]}}, m[7:0]};
      4'd6:    fmt_model = {56'd0, m[7:0]};
      4'd7:    fmt_model = {48'd0, m[15:0]};
      4'd8:    fmt_model = {32'd0, m[31:0]};
      default: fmt_model = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction
  assign fmt_res = fmt_model(fmt_tipo, fmt_reg, fmt_mem);

  function automatic bit misal(input logic [3:0] tp, input logic [63:0] ad);
`ifdef MEM_ALIGN_CHECK_EN
    if ((tp == 4'd0 || tp == 4'd3 || tp == 4'd8) && ad[1:0] != 2'b00) return 1'b1;
    if ((tp == 4'd1 || tp == 4'd4 || tp == 4'd7) && ad[0]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"}, {58'd0, busy, done, err, mem_rd, mem_wr, 1'b0}, 64'd0);
    check_eq({tag, "_rdata"}, rdata, 64'd0);
    check_eq({tag, "_maddr"}, mem_addr, 64'd0);
    check_eq({tag, "_mwdata"}, mem_wdata, 64'd0);
    check_eq({tag, "_fmt"}, fmt_reg | fmt_mem | {60'd0, fmt_tipo}, 64'd0);
  endtask

  // Called just after a falling edge. Accepts at the next rising edge (t) and follows
  // the access up to its done cycle; 'hold' keeps req high with nxt_* for back-to-back.
  task automatic do_access(input logic [3:0] tp, input logic [63:0] ad, input logic [63:0] wd,
                           input logic [63:0] mw, input bit hold);
    bit          legal, store;
    int          exp_done;
    int          rd_cnt, rd_cyc, wr_cnt, wr_cyc, busy_cnt, done_cyc, leak;
    logic [63:0] rd_addr, wr_addr, wr_data, exp_wd;
    logic        err_obs, busy_done;
    logic [63:0] rdata_obs, maddr_done;
    legal    = (tp <= 4'd8) && !misal(tp, ad);
    store    = (tp <= 4'd2);
    exp_done = legal ? 3 + LAT : 1;
    exp_wd   = fmt_model(tp, wd, mw);
    rd_cnt = 0; rd_cyc = 0; wr_cnt = 0; wr_cyc = 0; busy_cnt = 0; done_cyc = 0; leak = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; err_obs = 1'b0; busy_done = 1'b1;
    rdata_obs = '0; maddr_done = '1;
    req = 1'b1; tipo = tp; addr = ad; wdata = wd; mem_word = mw;
    @(posedge clk);
    #1;
    if (hold) begin
      tipo = nxt_tp; addr = nxt_ad; wdata = nxt_wd;
    end else begin
      req = (exp_done > 1); tipo = 4'($urandom); addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    end
    if (legal && !store) exp_rdata = fmt_model(tp, wd, mw);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!hold && (k >= exp_done || done)) req = 1'b0;
      if (mem_rd) begin
        rd_cnt++;
        if (rd_cnt == 1) begin rd_cyc = k; rd_addr = mem_addr; end
      end
      if (mem_wr) begin
        wr_cnt++;
        if (wr_cnt == 1) begin wr_cyc = k; wr_addr = mem_addr; wr_data = mem_wdata; end
      end else if (mem_wdata != 64'd0) leak++;
      if (done) begin
        done_cyc = k; err_obs = err; rdata_obs = rdata; busy_done = busy; maddr_done = mem_addr;
        break;
      end
      if (busy) busy_cnt++;
    end
    check_eq("done_cycle", 64'(done_cyc), 64'(exp_done));
    check_eq("err", {63'd0, err_obs}, {63'd0, !legal});
    check_eq("rd_count", 64'(rd_cnt), legal ? 64'd1 : 64'd0);
    check_eq("wr_count", 64'(wr_cnt), (legal && store) ? 64'd1 : 64'd0);
    check_eq("busy_cycles", 64'(busy_cnt), 64'(exp_done - 1));
    check_eq("busy_at_done", {63'd0, busy_done}, 64'd0);
    check_eq("maddr_idle", maddr_done, 64'd0);
    check_eq("wdata_leak", 64'(leak), 64'd0);
    check_eq("rdata", rdata_obs, exp_rdata);
    if (legal) begin
      check_eq("rd_cycle", 64'(rd_cyc), 64'd1);
      check_eq("rd_addr", rd_addr, ad);
    end
    if (legal && store) begin
      check_eq("wr_cycle", 64'(wr_cyc), 64'(2 + LAT));
      check_eq("wr_addr", wr_addr, ad);
      check_eq("wr_data", wr_data, exp_wd);
    end
  endtask

  task automatic reset_mid_store();
    int wr_seen;
    wr_seen = 0;
    req = 1'b1; tipo = 4'd0; addr = 64'h0000_0000_0000_3000;
    wdata = 64'h1111_2222_3333_4444; mem_word = 64'h5555_6666_7777_8888;
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (mem_wr) wr_seen++;
    end
    reset = 1'b0;
    @(negedge clk);
    exp_rdata = 64'd0;
    check_all_zero("rst_mid");
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_wr || busy) wr_seen++;
    end
    check_eq("rst_no_write", 64'(wr_seen), 64'd0);
  endtask

  logic [3:0]  c_tp;
  logic [63:0] c_ad, c_wd, c_mw;
  bit          c_hold;

  initial begin
    reset = 1'b0; req = 1'b0; tipo = '0; addr = '0; wdata = '0; mem_word = '0;
    exp_rdata = '0; nxt_tp = '0; nxt_ad = '0; nxt_wd = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    do_access(4'd5, 64'h0000_0000_0000_1000, 64'h0, 64'h0123_4567_89AB_CD80, 1'b0);
    check_eq("lb_example", rdata, 64'hFFFF_FFFF_FFFF_FF80);
    do_access(4'd1, 64'h0000_0000_0000_2000, 64'h0000_0000_0000_1234, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    do_access(4'hF, 64'h0000_0000_0000_2008, 64'h55, 64'h77, 1'b0);

    nxt_tp = 4'd8; nxt_ad = 64'h0000_0000_0000_4008; nxt_wd = 64'h99;
    do_access(4'd3, 64'h0000_0000_0000_4000, 64'h0, 64'h1234_5678_8765_4321, 1'b1);
    do_access(4'd8, 64'h0000_0000_0000_4008, 64'h99, 64'h1234_5678_8765_4321, 1'b0);
    check_eq("lwu_example", rdata, 64'h0000_0000_8765_4321);

    reset_mid_store();
    do_access(4'd6, 64'h0000_0000_0000_5001, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
    do_access(4'd0, 64'h0000_0000_0000_6002, 64'hCAFE_F00D, 64'h1111_2222_3333_4444, 1'b0);

    c_tp = 4'd3; c_ad = {$urandom, $urandom}; c_wd = {$urandom, $urandom}; c_mw = {$urandom, $urandom};
    for (int i = 0; i < 60; i++) begin
      nxt_tp = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      nxt_ad = {$urandom, $urandom};
      nxt_wd = {$urandom, $urandom};
      c_hold = ($urandom_range(0, 3) == 0);
      do_access(c_tp, c_ad, c_wd, c_mw, c_hold);
      if (!c_hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      c_tp = nxt_tp; c_ad = nxt_ad; c_wd = nxt_wd; c_mw = {$urandom, $urandom};
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1);
  end

endmodule
